// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and defaults for the two-port SDRAM host arbiter.
package sdram_port_arbiter_pkg;

    // bank + row + col = 2 + 13 + 9
    localparam int unsigned HaddrWidthDefault = 24;
    localparam int unsigned DataWidth         = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// One requester port of the SDRAM arbiter: command handshake plus per-port completion.
interface sdram_port_arbiter_if
    import sdram_port_arbiter_pkg::*;
#(
    parameter int unsigned HADDR_WIDTH = HaddrWidthDefault
) ();

    logic                   req;
    logic                   we;
    logic [HADDR_WIDTH-1:0] addr;
    logic [DataWidth-1:0]   wdata;
    logic                   gnt;
    logic [DataWidth-1:0]   rdata;
    logic                   rvalid;
    logic                   done;

    // Requester side (video/CPU master).
    modport master (
        output req, we, addr, wdata,
        input  gnt, rdata, rvalid, done
    );

    // Arbiter side.
    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdata, rvalid, done
    );

endinterface

// File: rtl/sdram_port_arbiter_rr_arbiter2.sv
// Two-way winner select: round-robin on a tie, or P0-wins when FIXED_PRIO is set.
module sdram_port_arbiter_rr_arbiter2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    output logic       winner_o,
    output logic       valid_o
);

    // Lone requester always wins; a tie goes to the port that did not win last.
    always_comb begin
        valid_o = |req_i;
        if (req_i == 2'b11) begin
            winner_o = FIXED_PRIO ? 1'b0 : ~rr_last_i;
        end else begin
            winner_o = req_i[1];
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one sdram_controller host interface between two requester ports,
// one transaction outstanding at a time, completions routed to the owner only.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int unsigned HADDR_WIDTH = HaddrWidthDefault,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sdram_port_arbiter_if.slave    p0,
    sdram_port_arbiter_if.slave    p1,
    output logic [HADDR_WIDTH-1:0] wr_addr,
    output logic [DataWidth-1:0]   wr_data,
    output logic                   wr_enable,
    output logic [HADDR_WIDTH-1:0] rd_addr,
    output logic                   rd_enable,
    input  logic [DataWidth-1:0]   rd_data,
    input  logic                   rd_ready,
    input  logic                   busy
);

    arb_state_e                  state_q, state_d;
    logic                        owner_q, owner_d;
    logic                        rr_last_q, rr_last_d;
    logic                        we_q, we_d;
    logic [HADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DataWidth-1:0]        wdata_q, wdata_d;
    logic [1:0]                  gnt_q, gnt_d;
    logic [1:0]                  rvalid_q, rvalid_d;
    logic [1:0]                  done_q, done_d;
    logic [1:0][DataWidth-1:0]   rdata_q, rdata_d;

    logic [1:0] req;
    logic       win;
    logic       win_valid;

    assign req = {p1.req, p0.req};

    sdram_port_arbiter_rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arbiter2 (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .winner_o  (win),
        .valid_o   (win_valid)
    );

    // Next-state: grant/latch in IDLE, hold enable in ISSUE, collect data in WAIT.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        gnt_d     = '0;
        rvalid_d  = '0;
        done_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d      = StIssue;
                    owner_d      = win;
                    rr_last_d    = win;
                    we_d         = win ? p1.we    : p0.we;
                    addr_d       = win ? p1.addr  : p0.addr;
                    wdata_d      = win ? p1.wdata : p0.wdata;
                    gnt_d[win]   = 1'b1;
                end
            end
            // Controller ignores enables during init/refresh, so keep presenting.
            StIssue: begin
                if (busy) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (rd_ready) begin
                    rdata_d[owner_q]  = rd_data;
                    rvalid_d[owner_q] = 1'b1;
                end
                if (!busy) begin
                    state_d          = StDone;
                    done_d[owner_q]  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            done_q    <= done_d;
        end
    end

    assign wr_addr   = addr_q;
    assign rd_addr   = addr_q;
    assign wr_data   = wdata_q;
    assign wr_enable = (state_q == StIssue) &  we_q;
    assign rd_enable = (state_q == StIssue) & ~we_q;

    assign p0.gnt    = gnt_q[0];
    assign p1.gnt    = gnt_q[1];
    assign p0.rvalid = rvalid_q[0];
    assign p1.rvalid = rvalid_q[1];
    assign p0.done   = done_q[0];
    assign p1.done   = done_q[1];
    assign p0.rdata  = rdata_q[0];
    assign p1.rdata  = rdata_q[1];

endmodule
